// File: rtl/tag_pkg.sv
// Shared types and size helpers for the DIFT tag memory controller.
package tag_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } tag_state_e;

    // One tag bit per data byte.
    function automatic int unsigned calc_nb(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned calc_words(input int unsigned num_words,
                                               input int unsigned data_width);
        return num_words / calc_nb(data_width);
    endfunction

endpackage

// File: rtl/tag_mem_ctrl_if.sv
// Core-side tag request bus: req/gnt handshake with a one-cycle rvalid response.
interface tag_mem_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NB         = 4
);

    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [NB-1:0]         be;
    logic                  wtag;
    logic                  rvalid;
    logic [NB-1:0]         rtag;
    logic                  rtag_any;

    modport master (
        output req, addr, we, be, wtag,
        input  gnt, rvalid, rtag, rtag_any
    );

    modport slave (
        input  req, addr, we, be, wtag,
        output gnt, rvalid, rtag, rtag_any
    );

endinterface

// File: rtl/tag_clr_engine.sv
// Clear engine: walks a word range of the tag RAM writing zeros, one word per cycle.
module tag_clr_engine
    import tag_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 12,
    parameter  int unsigned NB         = 4,
    parameter  int unsigned WORDS      = 1024,
    localparam int unsigned LNB        = $clog2(NB),
    localparam int unsigned CW         = ADDR_WIDTH - LNB
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [CW-1:0]         words_i,
    output logic                  idle_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wr_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o
);

    tag_state_e    state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          unused_base_lsb;

    // The range is word-aligned; sub-word address bits are don't-care.
    assign unused_base_lsb = ^base_i[LNB-1:0];

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        idle_o  = (state_q == IDLE);
        busy_o  = (state_q != IDLE);
        done_o  = 1'b0;
        wr_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d   = base_i[ADDR_WIDTH-1:LNB];
                    cnt_d   = words_i;
                    state_d = (words_i == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                wr_o  = 1'b1;
                // Index wraps past the top of the RAM back to word 0.
                idx_d = (idx_q == CW'(WORDS - 1)) ? '0 : idx_q + 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_addr_o = {idx_q, {LNB{1'b0}}};

endmodule

// File: rtl/tag_mem_ctrl.sv
// Tag RAM request controller: muxes core accesses and the clear engine onto the RAM port
// and aligns the registered RAM read data with rvalid.
module tag_mem_ctrl
    import tag_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 12,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned NUM_WORDS  = 4096,
    localparam int unsigned NB         = calc_nb(DATA_WIDTH),
    localparam int unsigned WORDS      = calc_words(NUM_WORDS, DATA_WIDTH),
    localparam int unsigned CW         = ADDR_WIDTH - $clog2(NB)
) (
    input  logic                  clk,
    input  logic                  rst_i,
    tag_mem_ctrl_if.slave         bus,
    input  logic                  clr_start_i,
    input  logic [ADDR_WIDTH-1:0] clr_base_i,
    input  logic [CW-1:0]         clr_words_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_wdata_o,
    output logic                  ram_we_o,
    output logic [NB-1:0]         ram_be_o,
    input  logic [NB-1:0]         ram_rdata_i
);

    logic                  eng_idle;
    logic                  eng_wr;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic                  gnt;
    logic [NB-1:0]         rtag;

    logic                  rvalid_q, rvalid_d;
    logic [NB-1:0]         be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    tag_clr_engine #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB         (NB),
        .WORDS      (WORDS)
    ) u_clr (
        .clk       (clk),
        .rst_i     (rst_i),
        .start_i   (clr_start_i),
        .base_i    (clr_base_i),
        .words_i   (clr_words_i),
        .idle_o    (eng_idle),
        .busy_o    (clr_busy_o),
        .done_o    (clr_done_o),
        .wr_o      (eng_wr),
        .wr_addr_o (eng_addr)
    );

    // A clear start outranks a core request in the same cycle.
    assign gnt = bus.req & eng_idle & ~clr_start_i;

    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = 1'b0;
        ram_addr_o  = addr_q;
        if (eng_wr) begin
            ram_en_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_be_o   = '1;
            ram_addr_o = eng_addr;
        end else if (gnt) begin
            ram_en_o    = 1'b1;
            ram_we_o    = bus.we;
            ram_be_o    = bus.be;
            ram_wdata_o = bus.wtag;
            ram_addr_o  = bus.addr;
        end
    end

    // be is cleared when nothing is granted so rtag reads zero between responses.
    always_comb begin
        rvalid_d = gnt;
        be_d     = gnt ? bus.be : '0;
        addr_d   = ram_addr_o;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
        end
    end

    assign rtag         = ram_rdata_i & be_q;
    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid_q;
    assign bus.rtag     = rtag;
    assign bus.rtag_any = |rtag;

endmodule
